// File: rtl/mem_port_arbiter_if.sv
// Bundle of the split fetch/data requester ports and the shared LC-3b memory port.
// The master modport is the arbiter's view; slave is the CPU/memory side.
interface mem_port_arbiter_if #(
  parameter int WIDTH = 16
);
  logic             i_read;
  logic [WIDTH-1:0] i_address;
  logic [WIDTH-1:0] i_rdata;
  logic             i_resp;

  logic             d_read;
  logic             d_write;
  logic [1:0]       d_byte_enable;
  logic [WIDTH-1:0] d_address;
  logic [WIDTH-1:0] d_wdata;
  logic [WIDTH-1:0] d_rdata;
  logic             d_resp;

  logic             mem_read;
  logic             mem_write;
  logic [1:0]       mem_byte_enable;
  logic [WIDTH-1:0] mem_address;
  logic [WIDTH-1:0] mem_wdata;
  logic             mem_resp;
  logic [WIDTH-1:0] mem_rdata;

  modport master (
    input  i_read, i_address,
    output i_rdata, i_resp,
    input  d_read, d_write, d_byte_enable, d_address, d_wdata,
    output d_rdata, d_resp,
    output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    input  mem_resp, mem_rdata
  );

  modport slave (
    output i_read, i_address,
    input  i_rdata, i_resp,
    output d_read, d_write, d_byte_enable, d_address, d_wdata,
    input  d_rdata, d_resp,
    input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    output mem_resp, mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one LC-3b memory port between an instruction-fetch requester and a data
// requester; serializes transactions and returns each response to its owner.
module mem_port_arbiter #(
  parameter int WIDTH            = 16,
  parameter bit FIXED_D_PRIORITY = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.master bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SERVE_I = 2'd1;
  localparam logic [1:0] SERVE_D = 2'd2;

  logic [1:0] state_r;
  logic [1:0] state_next_s;
  logic       last_grant_r;
  logic       last_grant_next_s;
  logic       i_pend_s;
  logic       d_pend_s;

  // Arbitration in IDLE from registered state; granted owner held until mem_resp.
  always_comb begin
    state_next_s      = state_r;
    last_grant_next_s = last_grant_r;
    i_pend_s          = bus.i_read;
    d_pend_s          = bus.d_read | bus.d_write;
    case (state_r)
      IDLE: begin
        if (i_pend_s && d_pend_s) begin
          // last_grant_r = 1 means D went last, so I wins the tie in round-robin.
          if (FIXED_D_PRIORITY || (last_grant_r == 1'b0)) begin
            state_next_s      = SERVE_D;
            last_grant_next_s = 1'b1;
          end else begin
            state_next_s      = SERVE_I;
            last_grant_next_s = 1'b0;
          end
        end else if (i_pend_s) begin
          state_next_s      = SERVE_I;
          last_grant_next_s = 1'b0;
        end else if (d_pend_s) begin
          state_next_s      = SERVE_D;
          last_grant_next_s = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      SERVE_I, SERVE_D: begin
        if (bus.mem_resp) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = state_r;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State and fairness bookkeeping; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;
    end else begin
      state_r      <= state_next_s;
      last_grant_r <= last_grant_next_s;
    end
  end

  // Memory-side drive and response routing; strobes follow state, not the live request.
  always_comb begin
    bus.mem_read        = 1'b0;
    bus.mem_write       = 1'b0;
    bus.mem_byte_enable = 2'b11;
    bus.mem_address     = {WIDTH{1'b0}};
    bus.mem_wdata       = {WIDTH{1'b0}};
    bus.i_resp          = 1'b0;
    bus.d_resp          = 1'b0;
    case (state_r)
      SERVE_I: begin
        bus.mem_read    = 1'b1;
        bus.mem_address = bus.i_address;
        bus.i_resp      = bus.mem_resp;
      end
      SERVE_D: begin
        bus.mem_address = bus.d_address;
        bus.d_resp      = bus.mem_resp;
        if (bus.d_write) begin
          bus.mem_write       = 1'b1;
          bus.mem_wdata       = bus.d_wdata;
          bus.mem_byte_enable = bus.d_byte_enable;
        end else begin
          bus.mem_read = 1'b1;
        end
      end
      default: begin
        bus.mem_read = 1'b0;
      end
    endcase
  end

  assign bus.i_rdata = bus.mem_rdata;
  assign bus.d_rdata = bus.mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one round-robin instance and one fixed-D-priority instance.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.WIDTH(16)) bus0 ();
  mem_port_arbiter_if #(.WIDTH(16)) bus1 ();

  mem_port_arbiter #(.WIDTH(16), .FIXED_D_PRIORITY(1'b0)) dut_rr (
    .clk(clk), .reset(reset), .bus(bus0)
  );
  mem_port_arbiter #(.WIDTH(16), .FIXED_D_PRIORITY(1'b1)) dut_fp (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_mem0(input string tag, input logic rd, input logic wr,
                          input logic [1:0] be, input logic [15:0] addr, input logic [15:0] wdata);
    chk1 ({tag, "_rd"},   bus0.mem_read,  rd);
    chk1 ({tag, "_wr"},   bus0.mem_write, wr);
    chk16({tag, "_be"},   {14'd0, bus0.mem_byte_enable}, {14'd0, be});
    chk16({tag, "_addr"}, bus0.mem_address, addr);
    chk16({tag, "_wd"},   bus0.mem_wdata, wdata);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset = 1'b1;
    bus0.i_read = 1'b0; bus0.i_address = 16'h0000;
    bus0.d_read = 1'b0; bus0.d_write = 1'b0; bus0.d_byte_enable = 2'b11;
    bus0.d_address = 16'h0000; bus0.d_wdata = 16'h0000;
    bus0.mem_resp = 1'b0; bus0.mem_rdata = 16'h0000;
    bus1.i_read = 1'b0; bus1.i_address = 16'h0000;
    bus1.d_read = 1'b0; bus1.d_write = 1'b0; bus1.d_byte_enable = 2'b11;
    bus1.d_address = 16'h0000; bus1.d_wdata = 16'h0000;
    bus1.mem_resp = 1'b0; bus1.mem_rdata = 16'h0000;

    step(); step(); settle();
    chk_mem0("reset", 1'b0, 1'b0, 2'b11, 16'h0000, 16'h0000);
    chk1("reset_iresp", bus0.i_resp, 1'b0);
    chk1("reset_dresp", bus0.d_resp, 1'b0);
    reset = 1'b0;

    // I-only read, 3-cycle memory
    step();
    bus0.i_read = 1'b1; bus0.i_address = 16'h0040; settle();
    chk1("i_no_comb_grant", bus0.mem_read, 1'b0);
    step(); settle();
    chk_mem0("i_serve", 1'b1, 1'b0, 2'b11, 16'h0040, 16'h0000);
    chk1("i_wait1_resp", bus0.i_resp, 1'b0);
    step(); settle();
    chk1("i_wait2_rd", bus0.mem_read, 1'b1);
    chk1("i_wait2_resp", bus0.i_resp, 1'b0);
    step();
    bus0.mem_resp = 1'b1; bus0.mem_rdata = 16'h1234; settle();
    chk1("i_resp", bus0.i_resp, 1'b1);
    chk16("i_rdata", bus0.i_rdata, 16'h1234);
    chk1("i_dresp_quiet", bus0.d_resp, 1'b0);

    // D write, 1-cycle memory
    step();
    bus0.i_read = 1'b0; bus0.mem_resp = 1'b0;
    bus0.d_write = 1'b1; bus0.d_address = 16'h0100; bus0.d_wdata = 16'hBEEF;
    bus0.d_byte_enable = 2'b01; settle();
    chk_mem0("i_idle_after", 1'b0, 1'b0, 2'b11, 16'h0000, 16'h0000);
    chk1("i_idle_resp", bus0.i_resp, 1'b0);
    step(); settle();
    chk_mem0("d_write", 1'b0, 1'b1, 2'b01, 16'h0100, 16'hBEEF);
    chk1("d_write_noresp", bus0.d_resp, 1'b0);
    bus0.mem_resp = 1'b1; bus0.mem_rdata = 16'hDEAD; settle();
    chk1("d_write_resp", bus0.d_resp, 1'b1);
    chk1("d_write_iresp", bus0.i_resp, 1'b0);
    chk1("d_write_rd", bus0.mem_read, 1'b0);
    step();
    bus0.d_write = 1'b0; bus0.mem_resp = 1'b0; bus0.d_byte_enable = 2'b11; settle();
    chk_mem0("d_idle_after", 1'b0, 1'b0, 2'b11, 16'h0000, 16'h0000);
    chk1("d_idle_resp", bus0.d_resp, 1'b0);

    // mem_resp in IDLE is ignored
    bus0.mem_resp = 1'b1; settle();
    chk1("idle_resp_i", bus0.i_resp, 1'b0);
    chk1("idle_resp_d", bus0.d_resp, 1'b0);
    step();
    bus0.mem_resp = 1'b0; settle();
    chk1("idle_resp_stay", bus0.mem_read, 1'b0);

    // one I read so last_grant=I before reset
    bus0.i_read = 1'b1; bus0.i_address = 16'h0010;
    step();
    bus0.mem_resp = 1'b1; settle();
    chk1("pre_rr_iresp", bus0.i_resp, 1'b1);
    step();
    bus0.i_read = 1'b0; bus0.mem_resp = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;

    // round-robin contention
    bus0.i_read = 1'b1; bus0.d_read = 1'b1;
    bus0.i_address = 16'h0200; bus0.d_address = 16'h0300; settle();
    chk1("rr_idle", bus0.mem_read, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(); settle();
      chk16("rr_addr", bus0.mem_address, (k % 2 == 0) ? 16'h0200 : 16'h0300);
      chk1("rr_rd", bus0.mem_read, 1'b1);
      bus0.mem_resp = 1'b1; bus0.mem_rdata = 16'h1000 + 16'(k); settle();
      chk1("rr_iresp", bus0.i_resp, (k % 2 == 0));
      chk1("rr_dresp", bus0.d_resp, (k % 2 != 0));
      chk16("rr_rdata", (k % 2 == 0) ? bus0.i_rdata : bus0.d_rdata, 16'h1000 + 16'(k));
      step();
      bus0.mem_resp = 1'b0;
      if (k == 3) bus0.i_read = 1'b0;
      settle();
      chk1("rr_gap_rd", bus0.mem_read, 1'b0);
    end

    // reset during SERVE_D before mem_resp
    step(); settle();
    chk16("rst_d_addr", bus0.mem_address, 16'h0300);
    chk1("rst_d_rd", bus0.mem_read, 1'b1);
    reset = 1'b1; settle();
    chk1("rst_d_noresp", bus0.d_resp, 1'b0);
    step();
    reset = 1'b0; bus0.i_read = 1'b1; settle();
    chk_mem0("rst_after", 1'b0, 1'b0, 2'b11, 16'h0000, 16'h0000);
    chk1("rst_after_dresp", bus0.d_resp, 1'b0);
    step(); settle();
    chk16("rst_i_first", bus0.mem_address, 16'h0200);
    chk1("rst_i_rd", bus0.mem_read, 1'b1);
    bus0.mem_resp = 1'b1; settle();
    chk1("rst_i_resp", bus0.i_resp, 1'b1);
    step();
    bus0.i_read = 1'b0; bus0.d_read = 1'b0; bus0.mem_resp = 1'b0;

    // requester drops d_read while granted
    bus0.d_read = 1'b1; bus0.d_address = 16'h0500;
    step(); settle();
    chk1("drop_rd", bus0.mem_read, 1'b1);
    chk16("drop_addr", bus0.mem_address, 16'h0500);
    bus0.d_read = 1'b0; bus0.d_address = 16'h0777; settle();
    chk1("drop_rd_held", bus0.mem_read, 1'b1);
    chk16("drop_addr_follow", bus0.mem_address, 16'h0777);
    step(); settle();
    chk1("drop_rd_held2", bus0.mem_read, 1'b1);
    bus0.mem_resp = 1'b1; bus0.mem_rdata = 16'h4242; settle();
    chk1("drop_resp", bus0.d_resp, 1'b1);
    chk16("drop_rdata", bus0.d_rdata, 16'h4242);
    step();
    bus0.mem_resp = 1'b0; settle();
    chk1("drop_idle", bus0.mem_read, 1'b0);

    // d_read and d_write together act as a write
    bus0.d_read = 1'b1; bus0.d_write = 1'b1; bus0.d_address = 16'h0600;
    bus0.d_wdata = 16'h0F0F; bus0.d_byte_enable = 2'b10;
    step(); settle();
    chk_mem0("rw_both", 1'b0, 1'b1, 2'b10, 16'h0600, 16'h0F0F);
    bus0.mem_resp = 1'b1; settle();
    chk1("rw_both_resp", bus0.d_resp, 1'b1);
    step();
    bus0.d_read = 1'b0; bus0.d_write = 1'b0; bus0.mem_resp = 1'b0;

    // fixed D priority instance
    bus1.i_read = 1'b1; bus1.d_read = 1'b1;
    bus1.i_address = 16'h0A00; bus1.d_address = 16'h0D00;
    for (int k = 0; k < 3; k++) begin
      step(); settle();
      chk16("fp_d_addr", bus1.mem_address, 16'h0D00);
      chk1("fp_d_rd", bus1.mem_read, 1'b1);
      bus1.mem_resp = 1'b1; settle();
      chk1("fp_d_resp", bus1.d_resp, 1'b1);
      chk1("fp_i_quiet", bus1.i_resp, 1'b0);
      step();
      bus1.mem_resp = 1'b0;
      if (k == 2) bus1.d_read = 1'b0;
      settle();
      chk1("fp_gap_rd", bus1.mem_read, 1'b0);
    end
    step(); settle();
    chk16("fp_i_addr", bus1.mem_address, 16'h0A00);
    chk1("fp_i_rd", bus1.mem_read, 1'b1);
    bus1.mem_resp = 1'b1; settle();
    chk1("fp_i_resp", bus1.i_resp, 1'b1);
    step();
    bus1.i_read = 1'b0; bus1.mem_resp = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
